linear_interp: RTL and testbench
================================

Name: linear_interp

Overview:
Sequential fixed-point linear interpolator. Given two points (x0,y0), (x1,y1) and a query x, it computes y = y0 + (y1-y0)*(x-x0)/(x1-x0) using a multi-cycle restoring divider. It uses a valid/ready handshake on both input and output, and sits between lookup-table readout and downstream calibration/control logic.

Parameters:
DATA_WIDTH, 16, width of every coordinate input and of the result y (unsigned).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand set presented
in_ready  output  1  block idle, can accept operands
x0  input  DATA_WIDTH  first point abscissa, unsigned
y0  input  DATA_WIDTH  first point ordinate, unsigned
x1  input  DATA_WIDTH  second point abscissa, unsigned
y1  input  DATA_WIDTH  second point ordinate, unsigned
x  input  DATA_WIDTH  query abscissa, unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  DATA_WIDTH  interpolated result, unsigned, saturated
zero_div  output  1  result came from degenerate x0==x1 case

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on rst.
- Reset: state IDLE; in_ready=1, out_valid=0, y=0, zero_div=0. Reset mid-operation aborts the computation, and no result is produced.
- States: IDLE, SETUP, DIVIDE, FINISH, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE: on in_valid&&in_ready, register all five operands and go to SETUP.
- SETUP (1 cycle): compute signed (DATA_WIDTH+1)-bit values dy=y1-y0, dx=x1-x0, dxx=x-x0.
  - Compute signed product p=dy*dxx at full width (2*DATA_WIDTH+2 bits).
  - Record the result sign as sign(p) xor sign(dx), and load the magnitudes |p| and |dx| into the divider.
  - If dx==0, set the quotient to 0, set the zero_div flag, and go straight to FINISH. Otherwise go to DIVIDE.
- DIVIDE: restoring division of |p| by |dx|, one quotient bit per cycle, for exactly Q=2*DATA_WIDTH+2 cycles. Then go to FINISH.
- FINISH (1 cycle):
  - Quotient q = magnitude quotient with the recorded sign applied. Division truncates toward zero.
  - r = y0 + q, signed.
  - Saturate: r<0 gives y=0; r>2^DATA_WIDTH-1 gives y=2^DATA_WIDTH-1; otherwise y=r.
  - Register y and zero_div, then go to DONE.
- DONE: hold y, zero_div and out_valid=1 until out_ready=1, then go to IDLE. No new operand is accepted in that same cycle.
- Latency, counted from the accepting edge to the edge that asserts out_valid:
  - Normal case: Q+2 edges (36 for DATA_WIDTH=16).
  - dx==0 case: 2 edges.
- x outside [x0,x1] is not an error. The line is extrapolated and then saturated.
- The x1<x0 ordering is supported, since the signed differences handle it.
- y and zero_div keep their last result values after the output handshake, until the next FINISH or reset.
- Operand inputs are ignored while not in IDLE.
- in_valid/out_ready asserted during reset are ignored.

Test Plan:
- (0,0),(10,100), x=5 -> y=50, zero_div=0, out_valid exactly 36 cycles after accept.
- (10,100),(20,200), x=15 -> 150. (0,1000),(100,0), x=50 -> 500 (negative slope).
- Endpoints: (20,200),(40,400), x=20 -> 200; x=40 -> 400.
- Degenerate: (10,50),(10,50), x=10 -> y=50, zero_div=1, 2-cycle latency.
- Truncation and saturation:
  - (0,0),(3,10), x=1 -> 3.
  - (0,10),(3,0), x=1 -> 7.
  - (0,100),(10,0), x=20 -> 0.
  - (0,65000),(10,65535), x=100 -> 65535.
- Handshake: hold out_ready=0 for 5 cycles -> y and out_valid stable, in_ready=0. Assert rst during DIVIDE -> out_valid never rises, in_ready=1, y=0 next cycle.

Source files
------------

// File: rtl/linear_interp.sv
// Sequential fixed-point linear interpolator: y = y0 + (y1-y0)*(x-x0)/(x1-x0),
// signed setup, multi-cycle restoring divide, saturation to the unsigned output range.
module linear_interp #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x0,
  input  logic [DATA_WIDTH-1:0] y0,
  input  logic [DATA_WIDTH-1:0] x1,
  input  logic [DATA_WIDTH-1:0] y1,
  input  logic [DATA_WIDTH-1:0] x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  zero_div
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned QW = 2 * W + 2;
  localparam int unsigned CW = $clog2(QW);

  typedef enum logic [2:0] {IDLE, SETUP, DIVIDE, FINISH, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x0_q, y0_q, x1_q, y1_q, x_q;
  logic [W-1:0]    x0_d, y0_d, x1_d, y1_d, x_d;
  logic [QW-1:0]   num_q, num_d;
  logic [W:0]      rem_q, rem_d;
  logic [W:0]      den_q, den_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            zd_q, zd_d;
  logic [W-1:0]    y_q, y_d;
  logic            zero_div_q, zero_div_d;

  logic signed [W:0]    dy, dx, dxx;
  logic signed [QW-1:0] p;
  logic [QW-1:0]        p_mag;
  logic [W:0]           dx_mag;
  logic [W+1:0]         rem_sh;
  logic signed [QW:0]   q_s;
  logic [QW+1:0]        r;

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    x_d        = x_q;
    num_d      = num_q;
    rem_d      = rem_q;
    den_d      = den_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    zd_d       = zd_q;
    y_d        = y_q;
    zero_div_d = zero_div_q;

    dy     = $signed({1'b0, y1_q}) - $signed({1'b0, y0_q});
    dx     = $signed({1'b0, x1_q}) - $signed({1'b0, x0_q});
    dxx    = $signed({1'b0, x_q})  - $signed({1'b0, x0_q});
    p      = QW'(dy) * QW'(dxx);
    p_mag  = p[QW-1] ? -p : p;
    dx_mag = dx[W] ? -dx : dx;
    rem_sh = {rem_q, num_q[QW-1]};
    q_s    = neg_q ? -$signed({1'b0, num_q}) : $signed({1'b0, num_q});
    r      = {{(W + 4){1'b0}}, y0_q} + {q_s[QW], q_s};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          x_d     = x;
          state_d = SETUP;
        end
      end
      SETUP: begin
        neg_d = p[QW-1] ^ dx[W];
        den_d = dx_mag;
        rem_d = '0;
        cnt_d = '0;
        if (dx == '0) begin
          num_d   = '0;
          zd_d    = 1'b1;
          state_d = FINISH;
        end else begin
          num_d   = p_mag;
          zd_d    = 1'b0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        // num_q shifts the dividend out at the top and the quotient in at the bottom
        if (rem_sh >= {1'b0, den_q}) begin
          rem_d = W'(rem_sh - {1'b0, den_q});
          num_d = {num_q[QW-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W:0];
          num_d = {num_q[QW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) state_d = FINISH;
      end
      FINISH: begin
        if (r[QW+1])      y_d = '0;
        else if (|r[QW:W]) y_d = '1;
        else              y_d = r[W-1:0];
        zero_div_d = zd_q;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      x_q        <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      den_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      zd_q       <= 1'b0;
      y_q        <= '0;
      zero_div_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      x_q        <= x_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      den_q      <= den_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      zd_q       <= zd_d;
      y_q        <= y_d;
      zero_div_q <= zero_div_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign zero_div  = zero_div_q;
endmodule

// File: tb/tb_linear_interp.sv
// Directed bench for linear_interp: hand-computed results, latency, handshake and reset abort.
module tb_linear_interp;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x0, y0, x1, y1, x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        zero_div;

  int checks = 0;
  int errors = 0;

  linear_interp #(.DATA_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x0       (x0),
    .y0       (y0),
    .x1       (x1),
    .y1       (y1),
    .x        (x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .zero_div (zero_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_vec(input string tag,
                         input logic [15:0] a_x0, input logic [15:0] a_y0,
                         input logic [15:0] a_x1, input logic [15:0] a_y1,
                         input logic [15:0] a_x,
                         input logic [15:0] exp_y, input logic exp_zd,
                         input int exp_lat, input int hold);
    int lat;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    x0 = a_x0; y0 = a_y0; x1 = a_x1; y1 = a_y1; x = a_x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x0 = 16'hFFFF; y0 = 16'hFFFF; x1 = 16'h0; y1 = 16'h0; x = 16'h1234;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".y"}, {16'd0, y}, {16'd0, exp_y});
    check({tag, ".zd"}, {31'd0, zero_div}, {31'd0, exp_zd});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".hold_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, ".hold_y"}, {16'd0, y}, {16'd0, exp_y});
    end
    // new operands offered in the handshake cycle must not be taken
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".post_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, ".post_y"}, {16'd0, y}, {16'd0, exp_y});
    check({tag, ".post_zd"}, {31'd0, zero_div}, {31'd0, exp_zd});
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    x0 = 16'd1; y0 = 16'd2; x1 = 16'd3; y1 = 16'd4; x = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.y", {16'd0, y}, 32'd0);
    check("rst.zd", {31'd0, zero_div}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    run_vec("mid",     16'd0,  16'd0,     16'd10,  16'd100,   16'd5,   16'd50,    1'b0, 36, 0);
    run_vec("hold",    16'd10, 16'd100,   16'd20,  16'd200,   16'd15,  16'd150,   1'b0, 36, 5);
    run_vec("negslp",  16'd0,  16'd1000,  16'd100, 16'd0,     16'd50,  16'd500,   1'b0, 36, 0);
    run_vec("ep_lo",   16'd20, 16'd200,   16'd40,  16'd400,   16'd20,  16'd200,   1'b0, 36, 0);
    run_vec("ep_hi",   16'd20, 16'd200,   16'd40,  16'd400,   16'd40,  16'd400,   1'b0, 36, 0);
    run_vec("degen",   16'd10, 16'd50,    16'd10,  16'd50,    16'd10,  16'd50,    1'b1, 2,  2);
    run_vec("trunc_p", 16'd0,  16'd0,     16'd3,   16'd10,    16'd1,   16'd3,     1'b0, 36, 0);
    run_vec("trunc_n", 16'd0,  16'd10,    16'd3,   16'd0,     16'd1,   16'd7,     1'b0, 36, 0);
    run_vec("sat_lo",  16'd0,  16'd100,   16'd10,  16'd0,     16'd20,  16'd0,     1'b0, 36, 0);
    run_vec("sat_hi",  16'd0,  16'd65000, 16'd10,  16'd65535, 16'd100, 16'd65535, 1'b0, 36, 0);
    run_vec("rev",     16'd10, 16'd200,   16'd0,   16'd100,   16'd5,   16'd150,   1'b0, 36, 0);

    // abort a computation mid-divide; y currently holds 150 from the previous vector
    x0 = 16'd0; y0 = 16'd0; x1 = 16'd10; y1 = 16'd100; x = 16'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort.busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.in_ready", {31'd0, in_ready}, 32'd1);
    check("abort.out_valid", {31'd0, out_valid}, 32'd0);
    check("abort.y", {16'd0, y}, 32'd0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort.no_result", seen, 0);
    check("abort.idle", {31'd0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
